// File: rtl/trap_ctrl_mc_if.sv
// Trap request bundle between the issue channels, the trap controller and the interrupt SM.
interface trap_ctrl_mc_if #(
    parameter int N_CHAN = 2,
    parameter int TAG_W  = 32,
    parameter int CH_W   = (N_CHAN > 1) ? $clog2(N_CHAN) : 1
);
    logic [N_CHAN-1:0]       dec_valid;
    logic [5*N_CHAN-1:0]     dec_to;
    logic [5*N_CHAN-1:0]     dec_cmp;
    logic [TAG_W*N_CHAN-1:0] dec_tag;
    logic [N_CHAN-1:0]       en_int;
    logic                    flush;
    logic                    ovf_clr;
    logic                    trap_req;
    logic [CH_W-1:0]         trap_chan;
    logic [TAG_W-1:0]        trap_tag;
    logic [4:0]              trap_hit;
    logic                    trap_ack;
    logic [N_CHAN-1:0]       pend;
    logic [N_CHAN-1:0]       ovf;

    modport master (
        output dec_valid, dec_to, dec_cmp, dec_tag, en_int, flush, ovf_clr, trap_ack,
        input  trap_req, trap_chan, trap_tag, trap_hit, pend, ovf
    );

    modport slave (
        input  dec_valid, dec_to, dec_cmp, dec_tag, en_int, flush, ovf_clr, trap_ack,
        output trap_req, trap_chan, trap_tag, trap_hit, pend, ovf
    );
endinterface

// File: rtl/trap_ctrl_mc.sv
// Multi-channel trap controller: per-channel trap evaluation, one pending entry per channel,
// arbitration and req/ack hand-off to the interrupt state machine.
//
// state | meaning
// IDLE  | no trap offered; grant an eligible pending channel if any
// REQ   | trap offered on trap_req, outputs frozen until trap_ack
module trap_ctrl_mc #(
    parameter int N_CHAN = 2,
    parameter int TAG_W  = 32,
    parameter int RR     = 1,
    localparam int CH_W  = (N_CHAN > 1) ? $clog2(N_CHAN) : 1
) (
    input  logic           clk,
    input  logic           reset,
    trap_ctrl_mc_if.slave  bus
);
    typedef enum logic {IDLE, REQ} state_t;

    state_t            state, state_nxt;
    logic [N_CHAN-1:0] capture, drop, acking, elig;
    logic [N_CHAN-1:0] pend_q, ovf_q;
    logic [TAG_W-1:0]  tag_q [N_CHAN];
    logic [4:0]        hbits_q [N_CHAN];
    logic [CH_W-1:0]   ptr_q, chan_q, grant;
    logic              grant_vld;
    logic [TAG_W-1:0]  out_tag_q;
    logic [4:0]        out_hit_q;
    logic              trap_req;

    // A hit on the channel being acked refills the slot instead of overflowing.
    always_comb begin
        logic hi;
        capture = '0;
        drop    = '0;
        acking  = '0;
        hi      = 1'b0;
        for (int i = 0; i < N_CHAN; i++) begin
            hi = bus.dec_valid[i] & bus.en_int[i]
                 & (|(bus.dec_to[5*i +: 5] & bus.dec_cmp[5*i +: 5]));
            acking[i]  = (state == REQ) && bus.trap_ack && (chan_q == CH_W'(i));
            capture[i] = hi && !bus.flush && (!pend_q[i] || acking[i]);
            drop[i]    = hi && !bus.flush && pend_q[i] && !acking[i];
        end
    end

    // Grant is suppressed during flush so the latched entry is never one being discarded.
    assign elig = pend_q & bus.en_int & {N_CHAN{~bus.flush}};

    always_comb begin
        int              base;
        logic [CH_W-1:0] idx;
        base      = (RR != 0) ? int'(ptr_q) : 0;
        idx       = '0;
        grant     = '0;
        grant_vld = 1'b0;
        for (int k = 0; k < N_CHAN; k++) begin
            idx = CH_W'((base + k) % N_CHAN);
            if (!grant_vld && elig[idx]) begin
                grant     = idx;
                grant_vld = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_vld) state_nxt = REQ;
            REQ:     if (bus.trap_ack) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        trap_req = (state == REQ);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_q <= '0;
            ovf_q  <= '0;
        end else begin
            for (int i = 0; i < N_CHAN; i++) begin
                if (capture[i])
                    pend_q[i] <= 1'b1;
                else if (acking[i] || (bus.flush && !((state == REQ) && (chan_q == CH_W'(i)))))
                    pend_q[i] <= 1'b0;
                if (drop[i])
                    ovf_q[i] <= 1'b1;
                else if (bus.ovf_clr)
                    ovf_q[i] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < N_CHAN; i++) begin
            if (capture[i]) begin
                tag_q[i]   <= bus.dec_tag[TAG_W*i +: TAG_W];
                hbits_q[i] <= bus.dec_to[5*i +: 5] & bus.dec_cmp[5*i +: 5];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            chan_q    <= '0;
            out_tag_q <= '0;
            out_hit_q <= '0;
            ptr_q     <= '0;
        end else begin
            if ((state == IDLE) && grant_vld) begin
                chan_q    <= grant;
                out_tag_q <= tag_q[grant];
                out_hit_q <= hbits_q[grant];
            end
            if ((state == REQ) && bus.trap_ack)
                ptr_q <= (chan_q == CH_W'(N_CHAN - 1)) ? '0 : chan_q + CH_W'(1);
        end
    end

    assign bus.trap_req  = trap_req;
    assign bus.trap_chan = chan_q;
    assign bus.trap_tag  = out_tag_q;
    assign bus.trap_hit  = out_hit_q;
    assign bus.pend      = pend_q;
    assign bus.ovf       = ovf_q;
endmodule
